// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: baud divisors,
// parity encodings, FSM state codes and the per-frame configuration record.
package uart_pkg;

  // Parity_mode 00 and 11 both mean "no parity bit".
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  typedef struct packed {
    logic [2:0] baud_set;
    logic [1:0] data_len;
    logic [1:0] parity_mode;
    logic       stop2;
  } frame_cfg_t;

  function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [2:0] sel);
    case (sel)
      3'd0:    return clk_freq / 9600;
      3'd1:    return clk_freq / 19200;
      3'd2:    return clk_freq / 38400;
      3'd3:    return clk_freq / 57600;
      3'd4:    return clk_freq / 115200;
      3'd5:    return clk_freq / 230400;
      3'd6:    return clk_freq / 460800;
      default: return clk_freq / 921600;
    endcase
  endfunction

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Producer-side valid/ready byte channel into the UART transmitter.
interface uart_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] Data_in;
  logic              Data_valid;
  logic              Data_ready;

  modport master (output Data_in, output Data_valid, input Data_ready);
  modport slave  (input Data_in, input Data_valid, output Data_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data (not first-word-fall-through).
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk_sys,
  input  logic                   rst_b,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// FIFO-buffered UART transmitter with per-frame baud/length/parity/stop selection.
//   state  | meaning
//   IDLE   | line high, waiting for queued data and Tx_enable
//   LOAD   | FIFO word being read out, line still high
//   START  | start bit (line low)
//   DATA   | data bits, LSB first
//   PARITY | optional parity bit
//   STOP   | one or two stop bits; chains straight into START when more data queued
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  uart_frame_tx_if.slave              data_if,
  input  logic [2:0]                  Baud_set,
  input  logic [1:0]                  Data_len,
  input  logic [1:0]                  Parity_mode,
  input  logic                        Stop2,
  input  logic                        Tx_enable,
  output logic                        Uart_tx,
  output logic                        Tx_done,
  output logic                        Uart_state,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_level
);
  localparam int DIV_W = $clog2(CLK_FREQ / 9600 + 1);

  logic [2:0]        state_q;
  frame_cfg_t        cfg_q;
  frame_cfg_t        cfg_in;
  logic [DIV_W-1:0]  baud_cnt_q;
  logic [DIV_W-1:0]  div;
  logic [2:0]        bit_cnt_q;
  logic              stop_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              par_bit_q;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] data_mask;
  logic [DATA_W-1:0] masked;
  logic              par_calc;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;
  logic              bit_end;
  logic              data_last;
  logic              frame_last;
  logic              start_next;

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk_sys (Clk),
    .rst_b   (Reset_n),
    .wr_en   (data_if.Data_valid),
    .wr_data (data_if.Data_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (Fifo_level)
  );

  assign data_if.Data_ready = !fifo_full;

  assign cfg_in = '{baud_set: Baud_set, data_len: Data_len,
                    parity_mode: Parity_mode, stop2: Stop2};

  assign div        = DIV_W'(baud_div(CLK_FREQ, cfg_q.baud_set));
  assign bit_end    = (baud_cnt_q == div - 1'b1);
  assign data_last  = (bit_cnt_q == {1'b0, cfg_q.data_len} + 3'd4);
  assign frame_last = (state_q == ST_STOP) && bit_end && (stop_cnt_q == cfg_q.stop2);
  assign start_next = !fifo_empty && Tx_enable;
  assign fifo_rd    = ((state_q == ST_IDLE) || frame_last) && start_next;

  // Bits above the configured length never reach the line or the parity.
  assign data_mask = {DATA_W{1'b1}} >> (2'd3 - cfg_q.data_len);
  assign masked    = fifo_data & data_mask;
  assign par_calc  = (^masked) ^ (cfg_q.parity_mode == PAR_ODD);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) || (state_q == ST_LOAD) || bit_end) baud_cnt_q <= '0;
      else baud_cnt_q <= baud_cnt_q + 1'b1;

      case (state_q)
        ST_IDLE: if (start_next) state_q <= ST_LOAD;
        ST_LOAD: begin
          state_q <= ST_START;
          cfg_q   <= cfg_in;
        end
        ST_START: if (bit_end) begin
          shreg_q   <= masked;
          par_bit_q <= par_calc;
          bit_cnt_q <= '0;
          state_q   <= ST_DATA;
        end
        ST_DATA: if (bit_end) begin
          shreg_q <= shreg_q >> 1;
          if (data_last) begin
            stop_cnt_q <= 1'b0;
            state_q    <= parity_on(cfg_q.parity_mode) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: if (bit_end) begin
          stop_cnt_q <= 1'b0;
          state_q    <= ST_STOP;
        end
        ST_STOP: if (bit_end) begin
          if (stop_cnt_q == cfg_q.stop2) begin
            if (start_next) begin
              state_q <= ST_START;
              cfg_q   <= cfg_in;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            stop_cnt_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Uart_tx = 1'b1;
    case (state_q)
      ST_START:  Uart_tx = 1'b0;
      ST_DATA:   Uart_tx = shreg_q[0];
      ST_PARITY: Uart_tx = par_bit_q;
      default:   Uart_tx = 1'b1;
    endcase
  end

  assign Tx_done    = frame_last;
  assign Uart_state = (state_q != ST_IDLE) && (state_q != ST_LOAD);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: frame shape, parity, bursts, full FIFO, reset, baud change.
module tb_uart_frame_tx;

  logic       clk;
  logic       rst_n;
  logic [2:0] baud_set;
  logic [1:0] data_len;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       tx_enable;
  logic       uart_tx;
  logic       tx_done;
  logic       uart_state;
  logic [4:0] fifo_level;

  int  n_checks;
  int  n_errors;
  int  done_cnt;
  int  base;
  int  acc;
  logic rdy;

  uart_frame_tx_if #(.DATA_W(8)) u_if ();

  uart_frame_tx #(.CLK_FREQ(50_000_000), .FIFO_DEPTH(16), .DATA_W(8)) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .data_if     (u_if),
    .Baud_set    (baud_set),
    .Data_len    (data_len),
    .Parity_mode (parity_mode),
    .Stop2       (stop2),
    .Tx_enable   (tx_enable),
    .Uart_tx     (uart_tx),
    .Tx_done     (tx_done),
    .Uart_state  (uart_state),
    .Fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(posedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Entered at the negedge of a frame's first START cycle; returns one cycle past the checked span.
  task automatic expect_frame(input string tag, input logic [11:0] bits, input int nbits,
                              input int div, input bit complete);
    int line_bad;
    int busy_bad;
    int done_bad;
    line_bad = 0;
    busy_bad = 0;
    done_bad = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < div; c++) begin
        if (uart_tx !== bits[i]) line_bad++;
        if (uart_state !== 1'b1) busy_bad++;
        if (tx_done !== (complete && (i == nbits - 1) && (c == div - 1))) done_bad++;
        @(negedge clk);
      end
    end
    check_val({tag, " line"}, line_bad, 0);
    check_val({tag, " busy"}, busy_bad, 0);
    check_val({tag, " done"}, done_bad, 0);
  endtask

  task automatic push(input logic [7:0] b);
    u_if.Data_in    = b;
    u_if.Data_valid = 1'b1;
    @(negedge clk);
    u_if.Data_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    tx_enable = 1'b1;
    baud_set = 3'd4;
    data_len = 2'b11;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    u_if.Data_in = '0;
    u_if.Data_valid = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst tx", uart_tx, 1);
    check_val("rst done", tx_done, 0);
    check_val("rst state", uart_state, 0);
    check_val("rst level", fifo_level, 0);
    check_val("rst ready", u_if.Data_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: 8N1 0x63 at 115200, plus write->start latency
    push(8'h63);
    check_val("t1 level N", fifo_level, 1);
    check_val("t1 tx N", uart_tx, 1);
    @(negedge clk);
    check_val("t1 level N+1", fifo_level, 0);
    check_val("t1 tx N+1", uart_tx, 1);
    @(negedge clk);
    expect_frame("t1", {3'b001, 8'h63, 1'b0}, 10, 434, 1'b1);
    check_val("t1 idle", uart_state, 0);
    check_val("t1 done cnt", done_cnt, 1);

    // Test 2: 7 bits, even parity, 2 stop; bit 7 of 0xC1 must be ignored
    data_len = 2'b10;
    parity_mode = 2'b10;
    stop2 = 1'b1;
    push(8'hC1);
    repeat (2) @(negedge clk);
    expect_frame("t2", {1'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11, 434, 1'b1);
    check_val("t2 idle", uart_state, 0);

    // Test 3: 16-byte burst, frames back-to-back at 921600 (54 clocks)
    data_len = 2'b11;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    baud_set = 3'd7;
    base = done_cnt;
    acc = 0;
    fork
      begin
        int guard;
        guard = 0;
        while (acc < 16 && guard < 100) begin
          u_if.Data_in = acc[7:0];
          u_if.Data_valid = 1'b1;
          rdy = u_if.Data_ready;
          @(negedge clk);
          if (rdy) acc++;
          guard++;
        end
        u_if.Data_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 16; k++)
          expect_frame($sformatf("t3 f%0d", k), {3'b001, k[7:0], 1'b0}, 10, 54, 1'b1);
      end
    join
    check_val("t3 accepted", acc, 16);
    check_val("t3 pulses", done_cnt - base, 16);
    check_val("t3 idle", uart_state, 0);
    check_val("t3 level", fifo_level, 0);

    // Test 4: fill with Tx_enable low, then release
    tx_enable = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      u_if.Data_in = 8'h80 | acc[7:0];
      u_if.Data_valid = 1'b1;
      rdy = u_if.Data_ready;
      @(negedge clk);
      if (rdy) acc++;
    end
    check_val("t4 accepted", acc, 16);
    check_val("t4 level", fifo_level, 16);
    check_val("t4 ready", u_if.Data_ready, 0);
    check_val("t4 held", uart_state, 0);
    check_val("t4 tx", uart_tx, 1);
    base = done_cnt;
    u_if.Data_in = 8'hEE;
    tx_enable = 1'b1;
    @(negedge clk);
    u_if.Data_valid = 1'b0;
    check_val("t4 rd while full", fifo_level, 15);
    check_val("t4 ready after rd", u_if.Data_ready, 1);
    @(negedge clk);
    for (int k = 0; k < 16; k++)
      expect_frame($sformatf("t4 f%0d", k), {3'b001, 8'h80 | k[7:0], 1'b0}, 10, 54, 1'b1);
    check_val("t4 pulses", done_cnt - base, 16);
    check_val("t4 level end", fifo_level, 0);
    check_val("t4 idle", uart_state, 0);

    // Test 5: reset mid data bit 3 with a second byte queued
    push(8'h55);
    push(8'hAA);
    @(negedge clk);
    repeat (4 * 54 + 27) @(negedge clk);
    check_val("t5 bit3", uart_tx, 0);
    check_val("t5 queued", fifo_level, 1);
    base = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("t5 tx", uart_tx, 1);
    check_val("t5 state", uart_state, 0);
    check_val("t5 level", fifo_level, 0);
    repeat (700) @(negedge clk);
    check_val("t5 no done", done_cnt - base, 0);
    check_val("t5 stays idle", uart_state, 0);

    // Test 6: Baud_set 4 -> 0 mid-frame only affects the next frame
    baud_set = 3'd4;
    push(8'hA5);
    push(8'hC3);
    @(negedge clk);
    fork
      expect_frame("t6 f0", {3'b001, 8'hA5, 1'b0}, 10, 434, 1'b1);
      begin
        repeat (2000) @(negedge clk);
        baud_set = 3'd0;
      end
    join
    expect_frame("t6 f1", {3'b001, 8'hC3, 1'b0}, 2, 5208, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t6 end idle", uart_state, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
